// File: rtl/baud_pkg.sv
// ---------------------------------------------------------------------------
// baud_pkg
// Shared definitions for the baud tick generator: the controller state
// encoding and the smallest integer divisor the generator can run with.
// ---------------------------------------------------------------------------
package baud_pkg;

    // Controller states. RUN produces ticks, HOLD parks after a finished
    // oneshot frame, ERR parks after a start with an illegal divisor.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_ERR  = 2'd3
    } baud_state_t;

    // A divisor below this cannot place a midpoint tick distinct from the
    // end-of-bit tick.
    localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/frac_accum.sv
// ---------------------------------------------------------------------------
// frac_accum
// Fractional phase accumulator. On every enabled cycle (one per bit wrap) the
// fractional divisor is added to the accumulator; the overflow becomes the
// carry that stretches the following bit by one clock.
//
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   clr    in   synchronous clear of acc and carry (start / abort)
//   en     in   add inc into acc (asserted on a bit wrap)
//   inc    in   FRAC_W-bit fractional increment
//   carry  out  overflow of the most recent addition
// ---------------------------------------------------------------------------
module frac_accum #(
    parameter int FRAC_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [FRAC_W-1:0] inc,
    output logic              carry
);

    logic [FRAC_W-1:0] acc;

    // The carry is rewritten on every wrap, so it only ever lengthens the
    // single bit that follows the addition that produced it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            carry <= 1'b0;
        end else if (clr) begin
            acc   <= '0;
            carry <= 1'b0;
        end else if (en) begin
            {carry, acc} <= {1'b0, acc} + {1'b0, inc};
        end
    end

endmodule

// File: rtl/baud_tick_gen.sv
// ---------------------------------------------------------------------------
// baud_tick_gen
// Fractional baud-rate tick generator. Produces a mid-bit tick, an end-of-bit
// tick and a bit-clock level, either continuously or for a fixed number of
// bits (oneshot). The bit period is div_int clocks plus an occasional extra
// clock from the fractional accumulator.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   bps_start  in   level run request (0 aborts / returns to idle)
//   div_int    in   integer clocks per bit, minimum 2
//   div_frac   in   fractional clocks per bit in units of 2^-FRAC_W
//   oneshot    in   1: stop after nbits bits, 0: run continuously
//   nbits      in   bits per oneshot frame (0 behaves as 1)
//   tick_mid   out  one-cycle pulse at bit centre
//   tick_end   out  one-cycle pulse at bit end
//   clk_bps    out  high from tick_mid until tick_end
//   done       out  one-cycle pulse with the last oneshot tick_end
//   busy       out  high while running
//   cfg_err    out  high while parked on an illegal divisor
// ---------------------------------------------------------------------------
module baud_tick_gen
    import baud_pkg::*;
#(
    parameter int DIV_W   = 16,
    parameter int FRAC_W  = 4,
    parameter int NBITS_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               bps_start,
    input  logic [DIV_W-1:0]   div_int,
    input  logic [FRAC_W-1:0]  div_frac,
    input  logic               oneshot,
    input  logic [NBITS_W-1:0] nbits,
    output logic               tick_mid,
    output logic               tick_end,
    output logic               clk_bps,
    output logic               done,
    output logic               busy,
    output logic               cfg_err
);

    localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
    localparam logic [DIV_W:0]   ONE_X = (DIV_W+1)'(1);

    baud_state_t        state;
    baud_state_t        state_nxt;

    logic [DIV_W-1:0]   div_int_l;
    logic [FRAC_W-1:0]  div_frac_l;
    logic               oneshot_l;
    logic [NBITS_W-1:0] nbits_l;

    logic [DIV_W-1:0]   cnt;
    logic [DIV_W-1:0]   bit_cnt;
    logic [DIV_W-1:0]   mid;
    logic [DIV_W-1:0]   bit_target;
    logic [DIV_W:0]     period_m1;
    logic               carry;

    logic               start_req;
    logic               cfg_bad;
    logic               run_go;
    logic               abort;
    logic               at_mid;
    logic               at_end;
    logic               wrap;
    logic               last_bit;

    logic               tick_mid_nxt;
    logic               tick_end_nxt;
    logic               clk_bps_nxt;
    logic               done_nxt;
    logic               busy_nxt;
    logic               cfg_err_nxt;

    // Decode of the current cycle. The end comparison is one bit wider so a
    // maximum divisor plus carry cannot overflow. The midpoint ignores the
    // carry: the stretched clock is always appended after the centre.
    always_comb begin
        start_req  = (state == ST_IDLE) && bps_start;
        cfg_bad    = (div_int < DIV_W'(MIN_DIV));
        run_go     = (state == ST_RUN) && bps_start;
        abort      = (state == ST_RUN) && !bps_start;
        mid        = (div_int_l - ONE) >> 1;
        period_m1  = {1'b0, div_int_l} + {{DIV_W{1'b0}}, carry} - ONE_X;
        at_mid     = run_go && (cnt == mid);
        at_end     = ({1'b0, cnt} == period_m1);
        wrap       = run_go && at_end;
        bit_target = (nbits_l == '0) ? ONE : DIV_W'(nbits_l);
        last_bit   = oneshot_l && ((bit_cnt + ONE) == bit_target);
    end

    // Controller next state and next registered outputs. An abort has
    // priority over any tick that the same cycle would otherwise produce.
    always_comb begin
        state_nxt    = state;
        tick_mid_nxt = 1'b0;
        tick_end_nxt = 1'b0;
        clk_bps_nxt  = 1'b0;
        done_nxt     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bps_start) begin
                    state_nxt = cfg_bad ? ST_ERR : ST_RUN;
                end
            end
            ST_RUN: begin
                if (!bps_start) begin
                    state_nxt = ST_IDLE;
                end else begin
                    tick_mid_nxt = at_mid;
                    tick_end_nxt = wrap;
                    if (at_mid) begin
                        clk_bps_nxt = 1'b1;
                    end else if (wrap) begin
                        clk_bps_nxt = 1'b0;
                    end else begin
                        clk_bps_nxt = clk_bps;
                    end
                    if (wrap && last_bit) begin
                        done_nxt  = 1'b1;
                        state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!bps_start) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ERR: begin
                if (!bps_start) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt    = (state_nxt == ST_RUN);
        cfg_err_nxt = (state_nxt == ST_ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Configuration is captured only on a start so that later changes on
    // the inputs cannot disturb a frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_int_l  <= '0;
            div_frac_l <= '0;
            oneshot_l  <= 1'b0;
            nbits_l    <= '0;
        end else if (start_req) begin
            div_int_l  <= div_int;
            div_frac_l <= div_frac;
            oneshot_l  <= oneshot;
            nbits_l    <= nbits;
        end
    end

    // Clock-within-bit and bit counters. Both freeze outside RUN, which is
    // what keeps HOLD quiet after a oneshot frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            bit_cnt <= '0;
        end else if (start_req || abort) begin
            cnt     <= '0;
            bit_cnt <= '0;
        end else if (run_go) begin
            cnt <= at_end ? '0 : cnt + ONE;
            if (wrap && oneshot_l) begin
                bit_cnt <= bit_cnt + ONE;
            end
        end
    end

    frac_accum #(
        .FRAC_W (FRAC_W)
    ) u_frac_accum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_req || abort),
        .en    (wrap),
        .inc   (div_frac_l),
        .carry (carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_mid <= 1'b0;
            tick_end <= 1'b0;
            clk_bps  <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            tick_mid <= tick_mid_nxt;
            tick_end <= tick_end_nxt;
            clk_bps  <= clk_bps_nxt;
            done     <= done_nxt;
            busy     <= busy_nxt;
            cfg_err  <= cfg_err_nxt;
        end
    end

endmodule
